i_cache_assoc: RTL

Parametrised set-associative instruction cache with multi-word lines and round-robin replacement. It sits between the MIPS core instruction port and the instruction-side SRAM-like bus bridge, and replaces the single-word direct-mapped cache. It adds the following:
- configurable associativity and line size;
- critical-word return after a full-line refill;
- a whole-cache invalidate sweep.

It is read-only: the bus side never writes.

---
 rtl/i_cache_assoc.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/i_cache_assoc.sv
// i_cache_assoc: read-only set-associative instruction cache with multi-word lines.
//
// Purpose
//   Sits between the core instruction port and the instruction-side SRAM-like
//   bus bridge. Hits answer in the request cycle. A miss refills the whole line,
//   word 0 to WORDS-1, with one bus request at a time. The requested word is
//   returned from the line buffer in the DONE cycle. Replacement uses the lowest
//   invalid way, or else the per-set round-robin victim pointer. inv_all clears
//   every valid bit, one set per cycle.
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   cpu_inst_req/addr           fetch request, address held until addr_ok
//   cpu_inst_wr/size/wdata      unused (fetch-only port)
//   cpu_inst_rdata/addr_ok/data_ok  response; addr_ok and data_ok coincide
//   inv_all                     one-cycle pulse, invalidate the whole cache
//   cache_inst_req/addr         bus word read request
//   cache_inst_wr/size/wdata    tied off: read, word, zero
//   cache_inst_rdata/addr_ok/data_ok  bus response
module i_cache_assoc #(
  parameter int unsigned WAYS         = 2,
  parameter int unsigned INDEX_WIDTH  = 7,
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_inst_req,
  input  logic        cpu_inst_wr,
  input  logic [1:0]  cpu_inst_size,
  input  logic [31:0] cpu_inst_addr,
  input  logic [31:0] cpu_inst_wdata,
  output logic [31:0] cpu_inst_rdata,
  output logic        cpu_inst_addr_ok,
  output logic        cpu_inst_data_ok,
  input  logic        inv_all,
  output logic        cache_inst_req,
  output logic        cache_inst_wr,
  output logic [1:0]  cache_inst_size,
  output logic [31:0] cache_inst_addr,
  output logic [31:0] cache_inst_wdata,
  input  logic [31:0] cache_inst_rdata,
  input  logic        cache_inst_addr_ok,
  input  logic        cache_inst_data_ok
);

  localparam int unsigned WAY_BITS  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned SETS      = 1 << INDEX_WIDTH;
  localparam int unsigned WORDS     = 1 << (OFFSET_WIDTH - 2);
  localparam int unsigned WORD_BITS = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
  localparam int unsigned TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_DONE, S_INV} state_t;

  state_t                 r_state, w_next;
  logic [WAYS-1:0]        r_valid  [SETS];
  logic [TAG_WIDTH-1:0]   r_tag    [WAYS][SETS];
  logic [31:0]            r_data   [WAYS][SETS][WORDS];
  logic [WAY_BITS-1:0]    r_victim [SETS];
  logic [31:0]            r_line   [WORDS];

  logic [TAG_WIDTH-1:0]   r_tag_l;
  logic [INDEX_WIDTH-1:0] r_index_l;
  logic [WORD_BITS-1:0]   r_word_l;
  logic [WORD_BITS-1:0]   r_k;
  logic [WAY_BITS-1:0]    r_fill;
  logic                   r_addr_rcv;
  logic                   r_inv_pend;
  logic [INDEX_WIDTH-1:0] r_set;

  logic [TAG_WIDTH-1:0]   w_tag;
  logic [INDEX_WIDTH-1:0] w_index;
  logic [WORD_BITS-1:0]   w_word;
  logic                   w_hit, w_free;
  logic [WAY_BITS-1:0]    w_hit_way, w_free_way, w_fill;
  logic                   w_miss_start, w_xfer;
  logic [OFFSET_WIDTH-1:0] w_off;
  logic                   w_unused;

  assign w_tag   = cpu_inst_addr[31 -: TAG_WIDTH];
  assign w_index = cpu_inst_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  // Shift-and-mask keeps the word select legal when a line holds one word.
  assign w_word  = WORD_BITS'((cpu_inst_addr >> 2) & (WORDS - 1));
  assign w_off   = OFFSET_WIDTH'({r_k, 2'b00});

  assign cache_inst_wr    = 1'b0;
  assign cache_inst_size  = 2'b10;
  assign cache_inst_wdata = '0;
  assign cache_inst_addr  = {r_tag_l, r_index_l, w_off};
  assign w_unused = ^{cpu_inst_wr, cpu_inst_size, cpu_inst_wdata, cpu_inst_addr[1:0]};

  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (r_valid[w_index][w] && (r_tag[w][w_index] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_BITS'(w);
      end
      if (!r_valid[w_index][w] && !w_free) begin
        w_free     = 1'b1;
        w_free_way = WAY_BITS'(w);
      end
    end
  end

  assign w_fill = w_free ? w_free_way : r_victim[w_index];

  always_comb begin
    w_next           = r_state;
    cpu_inst_addr_ok = 1'b0;
    cpu_inst_data_ok = 1'b0;
    cpu_inst_rdata   = '0;
    cache_inst_req   = 1'b0;
    w_miss_start     = 1'b0;
    w_xfer           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_inv_pend || inv_all) begin
          w_next = S_INV;
        end else if (cpu_inst_req && w_hit) begin
          cpu_inst_addr_ok = 1'b1;
          cpu_inst_data_ok = 1'b1;
          cpu_inst_rdata   = r_data[w_hit_way][w_index][w_word];
        end else if (cpu_inst_req) begin
          w_miss_start = 1'b1;
          w_next       = S_REFILL;
        end
      end
      S_REFILL: begin
        cache_inst_req = ~r_addr_rcv;
        // Data is only taken for an address the bus has accepted, so a
        // stale beat with nothing outstanding cannot land in the line.
        if (r_addr_rcv && cache_inst_data_ok) begin
          w_xfer = 1'b1;
          if (r_k == WORD_BITS'(WORDS - 1)) w_next = S_DONE;
        end
      end
      S_DONE: begin
        cpu_inst_addr_ok = 1'b1;
        cpu_inst_data_ok = 1'b1;
        cpu_inst_rdata   = r_line[r_word_l];
        w_next           = S_IDLE;
      end
      S_INV: begin
        if (r_set == INDEX_WIDTH'(SETS - 1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_valid    <= '{default: '0};
      r_victim   <= '{default: '0};
      r_tag_l    <= '0;
      r_index_l  <= '0;
      r_word_l   <= '0;
      r_k        <= '0;
      r_fill     <= '0;
      r_addr_rcv <= 1'b0;
      r_inv_pend <= 1'b0;
      r_set      <= '0;
    end else begin
      r_state <= w_next;

      if (w_miss_start) begin
        r_tag_l    <= w_tag;
        r_index_l  <= w_index;
        r_word_l   <= w_word;
        r_k        <= '0;
        r_fill     <= w_fill;
        r_addr_rcv <= 1'b0;
      end

      if (r_state == S_REFILL) begin
        if (w_xfer) begin
          r_addr_rcv <= 1'b0;
          r_k        <= r_k + WORD_BITS'(1);
        end else if (cache_inst_req && cache_inst_addr_ok) begin
          r_addr_rcv <= 1'b1;
        end
      end

      if (r_state == S_DONE) begin
        r_valid[r_index_l][r_fill] <= 1'b1;
        r_victim[r_index_l]        <= WAY_BITS'((32'(r_fill) + 32'd1) % WAYS);
      end

      if (r_state == S_IDLE) begin
        r_set <= '0;
      end else if (r_state == S_INV) begin
        r_valid[r_set] <= '0;
        r_set          <= r_set + INDEX_WIDTH'(1);
      end

      // Completion of a sweep wins over a pulse arriving during it, so a
      // pulse inside INV never triggers a second sweep.
      if (r_state == S_INV && w_next == S_IDLE) begin
        r_inv_pend <= 1'b0;
      end else if (inv_all && r_state != S_IDLE) begin
        r_inv_pend <= 1'b1;
      end
    end
  end

  // Line storage and tags need no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_xfer) begin
      r_data[r_fill][r_index_l][r_k] <= cache_inst_rdata;
      r_line[r_k]                    <= cache_inst_rdata;
    end
    if (r_state == S_DONE) begin
      r_tag[r_fill][r_index_l] <= r_tag_l;
    end
  end

endmodule
